axi_read_arbiter_2to1: RTL
==========================

Name: axi_read_arbiter_2to1

Overview:
Burst-granular two-master to one-slave AXI read-channel arbiter. It lets the noise-estimation memory reader (m0) and the Wiener memory reader (m1) share a single read port of the frame memory, replacing the dedicated second read channel. Arbitration is round-robin, and a grant is held from address handshake until the last data beat of that burst completes. It carries the AR and R channel subsets used by the memory masters: addr, len, valid/ready, data, last.

Parameters:
ADDR_WIDTH, 32, address width on all AR channels
DATA_WIDTH, 32, R data width (packed RGB pixel word)
LEN_WIDTH, 8, arlen width; a burst is arlen+1 beats
CNT_WIDTH, 16, width of the per-master completed-burst counters

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
m0_araddr  in  ADDR_WIDTH  master 0 read address
m0_arlen  in  LEN_WIDTH  master 0 burst length-1
m0_arvalid  in  1  master 0 address valid
m0_arready  out  1  master 0 address ready
m0_rdata  out  DATA_WIDTH  master 0 read data
m0_rvalid  out  1  master 0 data valid
m0_rlast  out  1  master 0 last beat
m0_rready  in  1  master 0 data ready
m1_*  same set as m0_*  master 1 (Wiener reader)
s_araddr  out  ADDR_WIDTH  slave read address
s_arlen  out  LEN_WIDTH  slave burst length-1
s_arvalid  out  1  slave address valid
s_arready  in  1  slave address ready
s_rdata  in  DATA_WIDTH  slave read data
s_rvalid  in  1  slave data valid
s_rlast  in  1  slave last beat
s_rready  out  1  slave data ready
grant  out  2  one-hot current owner, 00 when idle
busy  out  1  arbiter in ADDR or DATA
m0_burst_cnt  out  CNT_WIDTH  completed bursts for m0, wraps
m1_burst_cnt  out  CNT_WIDTH  completed bursts for m1, wraps
len_error  out  1  sticky: rlast/beat-count mismatch seen

Behaviour:
- Reset, and any rst=1 cycle including mid-burst, forces the following on the next edge. State=IDLE, grant=00, busy=0, last_owner=1 (so m0 wins first), counters=0, len_error=0, beat counter=0. All master-side and slave-side valid/ready outputs are 0 while in IDLE.
- States: IDLE, ADDR, DATA.
- IDLE: evaluate m0_arvalid and m1_arvalid.
  - One requester: grant it.
  - Both requesting: grant the master that is not last_owner.
  - Grant is registered. State goes to ADDR next cycle with grant one-hot and busy=1. With none requesting, stay in IDLE.
- ADDR:
  - s_araddr, s_arlen and s_arvalid are combinationally muxed from the granted master.
  - s_arready routes to the granted master's arready. The non-granted arready is 0.
  - On s_arvalid&s_arready: latch arlen into len_q, clear beat counter, go to DATA.
  - Masters hold address stable while arvalid=1 per AXI; the arbiter does not register the address.
- DATA:
  - s_rdata, s_rvalid and s_rlast route to the granted master. The non-granted master sees rvalid=0 and rlast=0, with rdata=0.
  - s_rready = granted master's rready.
  - Each s_rvalid&s_rready beat increments the beat counter.
  - On a beat with s_rlast=1, the burst ends:
    - If beat counter != len_q, set len_error.
    - Increment the owner's burst_cnt (wraps at 2^CNT_WIDTH).
    - Update last_owner, clear grant and busy, go to IDLE.
  - If beat counter reaches len_q without s_rlast, also set len_error. Stay in DATA until rlast.
- Latency: request seen in IDLE at cycle N gives s_arvalid at N+1. Last beat at cycle K allows the next grant to take effect at K+2 (one IDLE cycle between bursts).
- Fairness: under continuous requests from both masters, grants strictly alternate. No master waits more than one burst.
- A master dropping arvalid before its handshake (protocol violation) keeps its grant. There is no timeout.
- No outstanding-transaction overlap: one burst in flight total.

Decomposition:
- Package axi_arb_pkg holds:
  - arb_state_t enum {IDLE, ADDR, DATA}
  - localparams M0=0 and M1=1
  - a default LEN_WIDTH constant
- Sub-module rr_pick_2: combinational round-robin picker. Inputs req[1:0] and last_owner; output one-hot pick.
- Everything else is in the top arbiter: the FSM, muxes, counters and error flag.

Test Plan:
- m0 only: araddr=0x40, arlen=7, slave gives 8 beats with rlast on the 8th. Expect the following:
  - grant=01
  - 8 beats delivered to m0, m1_rvalid=0 throughout
  - m0_burst_cnt=1, len_error=0
  - back to IDLE
- Both request the same cycle after reset (m0 arlen=3, m1 arlen=3). Expect m0 granted first, then m1 at the 2nd cycle after m0's rlast beat, then m0 again. Counters read 2/1 after three bursts.
- Backpressure: s_arready held 0 for 5 cycles and m1_rready toggled each cycle. Expect m1_arready to mirror s_arready and s_rready to mirror m1_rready. No beat is lost: data 0..15 in order for arlen=15.
- Length mismatch: arlen=3, slave asserts rlast on beat 2. Expect len_error=1, sticky until rst, and the FSM to still return to IDLE.
- rst=1 during DATA beat 3 of 8. Expect the following:
  - grant=00, all valids 0 next cycle
  - counters 0
  - a new m1 request after release is granted normally
- Counter wrap with CNT_WIDTH=4: 17 m0 bursts → m0_burst_cnt=1.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int M0 = 0;
  localparam int M1 = 1;
  localparam int DEFAULT_LEN_WIDTH = 8;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin picker: with both requesting, the master that did not own last wins.
module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_owner ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_read_arbiter_2to1.sv
// Burst-granular round-robin arbiter sharing one AXI read port (AR + R subsets) between two masters.
module axi_read_arbiter_2to1
  import axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [LEN_WIDTH-1:0]  m0_arlen,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [LEN_WIDTH-1:0]  m1_arlen,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [LEN_WIDTH-1:0]  s_arlen,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_rvalid,
  input  logic                  s_rlast,
  output logic                  s_rready,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  m0_burst_cnt,
  output logic [CNT_WIDTH-1:0]  m1_burst_cnt,
  output logic                  len_error
);

  arb_state_t           state;
  logic                 last_owner;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH:0]   beat_cnt;
  logic [1:0]           pick;
  logic                 sel;
  logic                 in_addr;
  logic                 in_data;
  logic                 ar_fire;
  logic                 r_fire;
  logic                 len_hit;

  rr_pick_2 u_pick (
    .req        ({m1_arvalid, m0_arvalid}),
    .last_owner (last_owner),
    .pick       (pick)
  );

  assign sel     = grant[M1];
  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and only the granted master is connected in ADDR/DATA.
  assign s_araddr   = sel ? m1_araddr : m0_araddr;
  assign s_arlen    = sel ? m1_arlen : m0_arlen;
  assign s_arvalid  = in_addr & (sel ? m1_arvalid : m0_arvalid);
  assign m0_arready = in_addr & grant[M0] & s_arready;
  assign m1_arready = in_addr & grant[M1] & s_arready;

  assign m0_rvalid = in_data & grant[M0] & s_rvalid;
  assign m1_rvalid = in_data & grant[M1] & s_rvalid;
  assign m0_rlast  = in_data & grant[M0] & s_rlast;
  assign m1_rlast  = in_data & grant[M1] & s_rlast;
  assign m0_rdata  = (in_data & grant[M0]) ? s_rdata : '0;
  assign m1_rdata  = (in_data & grant[M1]) ? s_rdata : '0;
  assign s_rready  = in_data & (sel ? m1_rready : m0_rready);

  assign ar_fire = s_arvalid & s_arready;
  assign r_fire  = s_rvalid & s_rready;
  // beat_cnt holds the index of the beat being transferred, so the final beat sees len_q.
  assign len_hit = (beat_cnt == {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 2'b00;
      busy         <= 1'b0;
      last_owner   <= 1'b1;
      len_q        <= '0;
      beat_cnt     <= '0;
      m0_burst_cnt <= '0;
      m1_burst_cnt <= '0;
      len_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            grant <= pick;
            busy  <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ar_fire) begin
            len_q    <= sel ? m1_arlen : m0_arlen;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
            if (s_rlast) begin
              if (!len_hit) begin
                len_error <= 1'b1;
              end
              if (sel) begin
                m1_burst_cnt <= m1_burst_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
              end else begin
                m0_burst_cnt <= m0_burst_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
              end
              last_owner <= sel;
              grant      <= 2'b00;
              busy       <= 1'b0;
              state      <= IDLE;
            end else if (len_hit) begin
              len_error <= 1'b1;
            end
          end
        end
        default: begin
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
